// File: rtl/aixh_mxc_upper_ptile_cell_pe_seq_if.sv
// aixh_mxc_upper_ptile_cell_pe_seq_if: job command, input word stream and PE control bundle of the PE sequencer
interface aixh_mxc_upper_ptile_cell_pe_seq_if #(parameter int LEN_BITS = 16);
  logic                cmd_valid, cmd_ready, cmd_afresh;
  logic [1:0]          cmd_prec;
  logic [LEN_BITS-1:0] cmd_len;
  logic                in_valid, in_ready;
  logic [63:0]         in_data, pe_iydata;
  logic                pe_cvt_enable, pe_half_sel, pe_mul_enable, pe_acc_enable, pe_acc_afresh;
  logic [1:0]          pe_cvt_mode, pe_acc_mode;
  logic [2:0]          pe_mul_mode;
  logic                done, err;
  modport master (
    output cmd_valid, cmd_prec, cmd_len, cmd_afresh, in_valid, in_data,
    input  cmd_ready, in_ready, pe_iydata, pe_cvt_enable, pe_half_sel, pe_cvt_mode,
           pe_mul_enable, pe_mul_mode, pe_acc_enable, pe_acc_afresh, pe_acc_mode, done, err
  );
  modport slave (
    input  cmd_valid, cmd_prec, cmd_len, cmd_afresh, in_valid, in_data,
    output cmd_ready, in_ready, pe_iydata, pe_cvt_enable, pe_half_sel, pe_cvt_mode,
           pe_mul_enable, pe_mul_mode, pe_acc_enable, pe_acc_afresh, pe_acc_mode, done, err
  );
endinterface

// File: rtl/aixh_mxc_upper_ptile_cell_pe_seq.sv
// aixh_mxc_upper_ptile_cell_pe_seq: holds each input word on the PE for 2/4 passes with pipeline-aligned MAC/accumulate control
// Optional INT16 pass support: AIXH_MXC_PESEQ_INT16_EN (undefined: INT16 jobs flag err and run as zero-length)
`ifndef AIXH_MXC_UISPE_STAGES
`define AIXH_MXC_UISPE_STAGES 3
`endif
module aixh_mxc_upper_ptile_cell_pe_seq #(
  parameter int MSTAGES  = `AIXH_MXC_UISPE_STAGES - 1,
  parameter int LEN_BITS = 16
) (
  input logic aixh_core_clk2x,
  input logic aixh_core_rstn,
  aixh_mxc_upper_ptile_cell_pe_seq_if.slave io
);
  localparam int CW = $clog2(MSTAGES + 2);
`ifdef AIXH_MXC_PESEQ_INT16_EN
  localparam int PW = 2;
`else
  localparam int PW = 1;
`endif
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t              r_state;
  logic [LEN_BITS-1:0] r_rem;
  logic [1:0]          r_prec;
  logic                r_afresh, r_first, r_full;
  logic [PW-1:0]       r_pass;
  logic [63:0]         r_data;
  logic [2:0]          r_mul_mode;
  logic [MSTAGES:0]    r_dl_v;
  logic [MSTAGES:0][1:0] r_dl_m;
  logic [CW-1:0]       r_cnt;
  logic                w_run, w_issue, w_last, w_load, w_in_ready, w_err;
  logic [2:0]          w_code, w_mul_mode;
  logic [1:0]          w_acc_mode;
  logic [LEN_BITS-1:0] w_len;
  assign w_run      = r_state == S_RUN;
  assign w_issue    = w_run & r_full;
  assign w_in_ready = w_run & (r_rem != '0) & (!r_full | w_last);
  assign w_load     = io.in_valid & w_in_ready;
`ifdef AIXH_MXC_PESEQ_INT16_EN
  assign w_last     = w_issue & (r_prec[1] ? &r_pass : r_pass[0]);
  assign w_code     = r_prec[1] ? {1'b1, r_pass} : {1'b0, r_prec[0], r_pass[0]};
  assign w_mul_mode = !r_prec[1] ? {2'b00, r_prec[0]} :
                      r_pass == 2'd0 ? 3'b111 : r_pass == 2'd1 ? 3'b011 : r_pass == 2'd2 ? 3'b101 : 3'b001;
  assign w_acc_mode = !r_prec[1] ? 2'b00 : r_pass == 2'd0 ? 2'b00 : r_pass == 2'd3 ? 2'b10 : 2'b01;
  assign w_err      = 1'b0;
  assign w_len      = io.cmd_len;
`else
  assign w_last     = w_issue & r_pass[0];
  assign w_code     = {1'b0, r_prec[0], r_pass[0]};
  assign w_mul_mode = {2'b00, r_prec[0]};
  assign w_acc_mode = 2'b00;
  assign w_err      = r_first & r_prec[1];
  assign w_len      = io.cmd_prec[1] ? '0 : io.cmd_len;
`endif
  assign io.cmd_ready     = r_state == S_IDLE;
  assign io.in_ready      = w_in_ready;
  assign io.pe_iydata     = r_data;
  assign io.pe_cvt_enable = w_issue;
  assign io.pe_cvt_mode   = w_issue ? w_code[2:1] : 2'b00;
  assign io.pe_half_sel   = w_issue & w_code[0];
  assign io.pe_mul_enable = w_run | (r_state == S_DRAIN);
  assign io.pe_mul_mode   = r_mul_mode;
  assign io.pe_acc_enable = r_dl_v[MSTAGES];
  assign io.pe_acc_mode   = r_dl_m[MSTAGES];
  assign io.pe_acc_afresh = r_first & r_afresh;
  assign io.done          = r_state == S_DONE;
  assign io.err           = w_err;
  always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
    if (!aixh_core_rstn) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_prec     <= 2'b00;
      r_afresh   <= 1'b0;
      r_first    <= 1'b0;
      r_full     <= 1'b0;
      r_pass     <= '0;
      r_data     <= '0;
      r_mul_mode <= 3'b000;
      r_dl_v     <= '0;
      r_dl_m     <= '0;
      r_cnt      <= '0;
    end else begin
      r_first    <= 1'b0;
      r_mul_mode <= w_issue ? w_mul_mode : 3'b000;
      // issue-slot delay line; bubbles enter as invalid so they never accumulate
      r_dl_v     <= {r_dl_v[MSTAGES-1:0], w_issue};
      r_dl_m     <= {r_dl_m[MSTAGES-1:0], w_issue ? w_acc_mode : 2'b00};
      case (r_state)
        S_IDLE: if (io.cmd_valid) begin
          r_state  <= S_RUN;
          r_prec   <= io.cmd_prec;
          r_afresh <= io.cmd_afresh;
          r_rem    <= w_len;
          r_first  <= 1'b1;
        end
        S_RUN: if (r_rem == '0 && (!r_full || w_last)) begin
          r_state <= S_DRAIN;
          r_cnt   <= '0;
        end
        S_DRAIN: begin
          r_state <= r_cnt == CW'(MSTAGES) ? S_DONE : S_DRAIN;
          r_cnt   <= r_cnt + CW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
      // reload during the last pass keeps one pass per cycle
      if (w_load) begin
        r_data <= io.in_data;
        r_full <= 1'b1;
        r_pass <= '0;
        r_rem  <= r_rem - LEN_BITS'(1);
      end else if (w_last) begin
        r_full <= 1'b0;
        r_pass <= '0;
      end else if (w_issue) begin
        r_pass <= r_pass + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_aixh_mxc_upper_ptile_cell_pe_seq.sv
// tb_aixh_mxc_upper_ptile_cell_pe_seq: directed jobs push timed expectations; a negedge monitor pops and compares them
module tb_aixh_mxc_upper_ptile_cell_pe_seq;
  localparam int M = 2;
  typedef struct {int kind; int cyc; logic [79:0] val;} ev_t;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   inr_forbid = 1'b0;
  ev_t  sb[$];
  logic [63:0] w8[3] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5A5A_A5A5_0F0F_F0F0};
  logic [2:0]  mm[4] = '{3'b111, 3'b011, 3'b101, 3'b001};
  logic [1:0]  am[4] = '{2'b00, 2'b01, 2'b01, 2'b10};
  logic [79:0] rstv = {1'b1, 79'b0};
  logic [79:0] vec;

  aixh_mxc_upper_ptile_cell_pe_seq_if #(.LEN_BITS(16)) sif ();
  aixh_mxc_upper_ptile_cell_pe_seq #(.MSTAGES(M), .LEN_BITS(16)) dut (
    .aixh_core_clk2x(clk),
    .aixh_core_rstn (rst_n),
    .io             (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign vec = {sif.cmd_ready, sif.in_ready, sif.pe_cvt_enable, sif.pe_half_sel, sif.pe_cvt_mode,
                sif.pe_mul_enable, sif.pe_mul_mode, sif.pe_acc_enable, sif.pe_acc_afresh,
                sif.pe_acc_mode, sif.done, sif.err, sif.pe_iydata};

  function automatic string kname(input int k);
    case (k)
      0: return "cvt";
      1: return "mul";
      2: return "acc";
      3: return "afresh";
      4: return "done";
      5: return "err";
      6: return "outvec";
      default: return "cmd_ready";
    endcase
  endfunction

  function automatic int find(input int k);
    for (int i = 0; i < sb.size(); i++) if (sb[i].kind == k) return i;
    return -1;
  endfunction

  task automatic push(input int k, input int c, input logic [79:0] v);
    sb.push_back('{kind: k, cyc: c, val: v});
  endtask

  task automatic check(input int k, input bit o, input logic [79:0] a);
    int  i;
    bit  due;
    bit  due_only;
    due_only = (k == 1) || (k >= 6);
    i = find(k);
    while (i >= 0 && sb[i].cyc < cyc) begin
      n_cmp++; n_err++;
      $display("FAIL %s cyc=%0d stale expectation for cyc %0d exp=%h", kname(k), cyc, sb[i].cyc, sb[i].val);
      sb.delete(i);
      i = find(k);
    end
    due = i >= 0 && sb[i].cyc == cyc;
    if (due_only) begin
      if (due) begin
        n_cmp++;
        if (a !== sb[i].val) begin
          n_err++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", kname(k), cyc, a, sb[i].val);
        end
        sb.delete(i);
      end
    end else if (o || due) begin
      n_cmp++;
      if (!due) begin
        n_err++;
        $display("FAIL %s cyc=%0d unexpected got=%h exp=none", kname(k), cyc, a);
      end else if (!o) begin
        n_err++;
        $display("FAIL %s cyc=%0d missing got=none exp=%h", kname(k), cyc, sb[i].val);
      end else if (a !== sb[i].val) begin
        n_err++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", kname(k), cyc, a, sb[i].val);
      end
      if (due) sb.delete(i);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      check(0, sif.pe_cvt_enable, {13'b0, sif.pe_cvt_mode, sif.pe_half_sel, sif.pe_iydata});
      check(1, 1'b0, {76'b0, sif.pe_mul_enable, sif.pe_mul_mode});
      check(2, sif.pe_acc_enable, {78'b0, sif.pe_acc_mode});
      check(3, sif.pe_acc_afresh, 80'd1);
      check(4, sif.done, 80'd1);
      check(5, sif.err, 80'd1);
      check(6, 1'b0, vec);
      check(7, 1'b0, {79'b0, sif.cmd_ready});
      if (sif.pe_acc_afresh) begin
        n_cmp++;
        if (sif.pe_acc_enable) begin
          n_err++;
          $display("FAIL exclusion cyc=%0d got afresh=1 acc_enable=1 exp acc_enable=0", cyc);
        end
      end
      if (inr_forbid) begin
        n_cmp++;
        if (sif.in_ready) begin
          n_err++;
          $display("FAIL in_ready cyc=%0d got=1 exp=0", cyc);
        end
      end
    end
  end

  task automatic start(input logic [1:0] p, input int len, input logic a, output int t);
    @(posedge clk); #1;
    t = cyc;
    push(7, t, 80'd1);
    sif.cmd_valid = 1'b1; sif.cmd_prec = p; sif.cmd_len = 16'(len); sif.cmd_afresh = a;
    @(posedge clk); #1;
    sif.cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] w);
    sif.in_valid = 1'b1;
    sif.in_data  = w;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (sif.in_ready) break;
      if (i == 50) begin
        $display("FAIL send cyc=%0d in_ready never rose for word %h", cyc, w);
        $fatal(1, "input handshake stalled");
      end
    end
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
  endtask

  task automatic wait_idle;
    for (int i = 0; sb.size() != 0; i++) begin
      if (i == 60) begin
        $display("FAIL drain cyc=%0d pending=%0d exp=0", cyc, sb.size());
        $fatal(1, "expectations never met");
      end
      @(posedge clk);
    end
  endtask

  task automatic run_int8;
    int t;
    start(2'b01, 3, 1'b1, t);
    push(3, t + 1, 80'd1);
    for (int w = 0; w < 3; w++)
      for (int p = 0; p < 2; p++) begin
        push(0, t + 2 + 2 * w + p, {13'b0, 2'b01, p[0], w8[w]});
        push(1, t + 3 + 2 * w + p, {76'b0, 4'b1001});
        push(2, t + 5 + 2 * w + p, 80'd0);
      end
    push(4, t + 11, 80'd1);
    for (int w = 0; w < 3; w++) send(w8[w]);
    wait_idle;
  endtask

  initial begin : stim
    int t;
    logic [63:0] wa, wb, w16, wr;
    wa  = 64'h1111_2222_3333_4444;
    wb  = 64'hAAAA_BBBB_CCCC_DDDD;
    w16 = 64'h8000_7FFF_0001_FFFF;
    wr  = 64'hDEAD_BEEF_CAFE_F00D;
    rst_n = 1'b0;
    sif.cmd_valid = 1'b0; sif.cmd_prec = 2'b00; sif.cmd_len = '0; sif.cmd_afresh = 1'b0;
    sif.in_valid = 1'b0; sif.in_data = '0;
    push(6, 1, rstv);
    push(6, 2, rstv);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_int8;
    // INT4, second word arrives late: three bubble slots that must not accumulate
    start(2'b00, 2, 1'b0, t);
    push(0, t + 2, {13'b0, 3'b000, wa});
    push(0, t + 3, {13'b0, 3'b001, wa});
    push(0, t + 7, {13'b0, 3'b000, wb});
    push(0, t + 8, {13'b0, 3'b001, wb});
    for (int c = 1; c <= 11; c++) push(1, t + c, {76'b0, 4'b1000});
    push(1, t + 12, 80'd0);
    push(2, t + 5, 80'd0);
    push(2, t + 6, 80'd0);
    push(2, t + 10, 80'd0);
    push(2, t + 11, 80'd0);
    push(4, t + 12, 80'd1);
    send(wa);
    repeat (4) @(posedge clk);
    #1 send(wb);
    wait_idle;
    // zero length with afresh and a waiting input word
    start(2'b01, 0, 1'b1, t);
    push(3, t + 1, 80'd1);
    push(4, t + 1 + M + 2, 80'd1);
    inr_forbid = 1'b1;
    sif.in_valid = 1'b1; sif.in_data = wr;
    wait_idle;
    inr_forbid = 1'b0;
    sif.in_valid = 1'b0;
`ifdef AIXH_MXC_PESEQ_INT16_EN
    start(2'b10, 1, 1'b0, t);
    for (int p = 0; p < 4; p++) begin
      push(0, t + 2 + p, {13'b0, 1'b1, p[1:0], w16});
      push(1, t + 3 + p, {76'b0, 1'b1, mm[p]});
      push(2, t + 3 + M + p, {78'b0, am[p]});
    end
    push(4, t + 9, 80'd1);
    send(w16);
    wait_idle;
`else
    start(2'b10, 5, 1'b1, t);
    push(3, t + 1, 80'd1);
    push(5, t + 1, 80'd1);
    push(4, t + 1 + M + 2, 80'd1);
    inr_forbid = 1'b1;
    sif.in_valid = 1'b1; sif.in_data = w16;
    wait_idle;
    inr_forbid = 1'b0;
    sif.in_valid = 1'b0;
`endif
    // reset while draining: no done, everything back to reset values, then a clean job
    start(2'b01, 1, 1'b1, t);
    push(3, t + 1, 80'd1);
    push(0, t + 2, {13'b0, 3'b010, wr});
    push(0, t + 3, {13'b0, 3'b011, wr});
    push(1, t + 3, {76'b0, 4'b1001});
    push(1, t + 4, {76'b0, 4'b1001});
    push(6, t + 5, rstv);
    push(6, t + 6, rstv);
    send(wr);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle;
    run_int8;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aixh_mxc_upper_ptile_cell_pe_seq.md
# aixh_mxc_upper_ptile_cell_pe_seq

Per-cell control sequencer that sits directly upstream of the upper processing-tile cell PE. It accepts one job command and a stream of 64-bit input words, and holds each word on the PE `iydata` bus for 2 or 4 passes. It generates the PE convert-stage, MAC-stage and accumulate controls, time-aligned to the PE's multiply pipeline. It signals completion once the last partial product has been accumulated.

## Interface
- `MSTAGES`, default `` `AIXH_MXC_UISPE_STAGES - 1 `` (2): PE multiply pipeline depth; must be ≥1.
- `LEN_BITS`, default 16: width of the job word count.
- `aixh_core_clk2x` in 1: the only clock. All flops are rising-edge.
- `aixh_core_rstn` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1, `cmd_ready` out 1: job command handshake.
- `cmd_prec` in 2: precision. 00 = INT4, 01 = INT8, 1x = INT16.
- `cmd_len` in `LEN_BITS`: number of 64-bit words in the job.
- `cmd_afresh` in 1: clear the PE accumulator at job start.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 64: input word stream.
- `pe_iydata` out 64: registered word driven to the PE.
- `pe_cvt_enable`, `pe_half_sel` out 1 each; `pe_cvt_mode` out 2.
- `pe_mul_enable`, `pe_acc_enable`, `pe_acc_afresh` out 1 each; `pe_mul_mode` out 3; `pe_acc_mode` out 2.
- `done` out 1: one-cycle pulse at job completion.
- `err` out 1: one-cycle pulse when an unsupported precision is accepted.

## Operation
- **States.** IDLE, RUN, DRAIN, DONE. `cmd_ready` is 1 only in IDLE.
- **IDLE → RUN** on `cmd_valid`. The block latches prec, len and afresh.
- **Afresh.** `pe_acc_afresh` is 1 for the first RUN cycle only, and only if afresh was latched.
- **Word buffer.** One entry. `in_ready` = RUN & words remaining & (buffer empty | last pass issuing this cycle). A word is loaded on `in_valid & in_ready`.
- **Pass issue.** Each RUN cycle with a full buffer issues one pass with `pe_cvt_enable` = 1 and `{cvt_mode, half_sel}` = pass code. An empty buffer gives a bubble with `pe_cvt_enable` = 0.
- **INT4 passes.** 2 passes, codes 000, 001; mul_mode 000; acc_mode 00.
- **INT8 passes.** 2 passes, codes 010, 011; mul_mode 001; acc_mode 00.
- **INT16 passes.** 4 passes, in order:
  - 100: mul_mode 111, acc_mode 00
  - 101: mul_mode 011, acc_mode 01
  - 110: mul_mode 101, acc_mode 01
  - 111: mul_mode 001, acc_mode 10
- **RUN → DRAIN** in the cycle after the last pass of the last word. `cmd_len` = 0 goes to DRAIN after the single RUN cycle.
- **DRAIN** lasts exactly `MSTAGES`+1 cycles, then goes to DONE.
- **DONE** asserts `done` for 1 cycle, then returns to IDLE.
- **MAC control.** `pe_mul_enable` = 1 throughout RUN and DRAIN, so the PE pipe shifts every cycle including bubbles.
- **Delay line.** A valid/mode delay line carries {valid, acc_mode} for each issue slot. `pe_acc_enable` is asserted only for slots that carried a pass. Bubble slots never accumulate.
- **Exclusion.** `pe_acc_afresh` and `pe_acc_enable` are never 1 in the same cycle. Afresh always precedes the first accumulate by ≥`MSTAGES`+1 cycles.
- **Reset values.** Every output is 0 except `cmd_ready` = 1. `pe_iydata` resets to 0. State resets to IDLE, the buffer to empty, and the delay line to invalid.
- **Reset mid-job.** The job is abandoned immediately with no `done`. The PE accumulator is not reset, so the next job must use afresh.

## Timing
- For a pass issued at cycle c:
  - PE `oydata` is valid in c+1.
  - `pe_mul_mode` for that pass is driven in c+1, aligned with `oydata`.
  - `pe_acc_enable` and `pe_acc_mode` for that pass are driven in c+`MSTAGES`+1.
- **Throughput.** 1 pass/cycle with no bubbles under a continuous `in_valid`, because the buffer reloads during the last pass.
- **Done latency.** `done` comes `MSTAGES`+2 cycles after the last issued pass. `cmd_ready` returns 1 the cycle after `done`.
- **Holding.** `pe_iydata` only changes on a word load and is stable across all passes of a word.

## Configuration
- Macro: `AIXH_MXC_PESEQ_INT16_EN`.
- **Defined:** INT16 operates as described above.
- **Undefined:**
  - `cmd_prec` = 1x is accepted with an `err` pulse in the first RUN cycle.
  - The job is treated as `cmd_len` = 0: no `in_ready`, no passes, afresh honoured, normal `done`.
  - INT16 pass logic is not synthesized.

## Test plan
- **INT8 streaming.** MSTAGES=2, prec=01, len=3, afresh=1, accept at cycle 0, `in_valid` constant → afresh at cycle 1; passes at cycles 2–7 with codes 010,011 repeating; `acc_enable` at cycles 5–10; `done` at cycle 11.
- **INT16 single word.** len=1, word 0x8000_7FFF_0001_FFFF → 4 passes with mul_mode 111,011,101,001 and acc_mode 00,01,01,10 delayed by 3 cycles; `pe_iydata` held for all 4 passes.
- **Input bubbles.** INT4, len=2, second word delayed by 3 cycles → 3 bubble cycles with `cvt_enable`=0; `mul_enable` stays 1; exactly 4 `acc_enable` cycles.
- **Zero length.** len=0, afresh=1 → afresh in cycle 1; no `in_ready`, `cvt_enable` or `acc_enable`; `done` at cycle 1+`MSTAGES`+2.
- **Reset mid-job.** Assert reset during DRAIN → all outputs 0 and `cmd_ready`=1 while reset is held; no `done`; the next job runs normally.
- **Macro undefined.** prec=10, len=5 → `err` pulse, zero `in_ready`, `done` as in the zero-length case.
